trng_ctrl: RTL and testbench
============================

TRNG_CTRL -- requirements
Module: trng_ctrl

Interface
REQ-001 Parameter WARMUP_CYCLES, default 64: cycles trng_en is held high before the first sample is taken; legal range 1..65535.
REQ-002 Parameter REPEAT_LIMIT, default 32: number of consecutive identical raw samples that trips the health error; legal range 2..255.
REQ-003 clk  input  1  single clock for all logic; samples trng_out on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  level request to run the generator; deassertion aborts any activity.
REQ-006 debias_en  input  1  1 = von Neumann debiasing, 0 = raw bits; sampled only in IDLE.
REQ-007 trng_en  output  1  enable to the ring-oscillator TRNG.
REQ-008 trng_out  input  1  random bit from the TRNG, already registered in clk domain.
REQ-009 data  output  32  collected random word, newest bit in bit 0.
REQ-010 data_valid  output  1  data holds a complete word.
REQ-011 data_ready  input  1  consumer accepts data when data_valid && data_ready.
REQ-012 busy  output  1  high in WARMUP and COLLECT.
REQ-013 error  output  1  health-test failure, sticky until enable low.

Function
REQ-014 States: IDLE, WARMUP, COLLECT, VALID, ERROR; encoded FSM, one state per cycle.
REQ-015 IDLE: trng_en=0, counters cleared; enable=1 -> WARMUP next cycle, latch debias_en into mode register.
REQ-016 WARMUP: trng_en=1; cycle counter counts WARMUP_CYCLES cycles, then -> COLLECT; trng_out ignored.
REQ-017 COLLECT raw mode: every cycle shift word {word[30:0], trng_out}, bit count +1; at 32nd bit -> VALID next cycle.
REQ-018 COLLECT debias mode: samples taken in pairs (a,b); a!=b emits a into word (01->0, 10->1); 00/11 discarded; pair state cleared on entry to COLLECT.
REQ-019 VALID: data_valid=1, data stable, trng_en stays 1, no sampling; handshake -> COLLECT next cycle with bit count 0 and pair state cleared.
REQ-020 data_valid asserted no earlier than the cycle after the 32nd bit is stored; data changes only in COLLECT.
REQ-021 Health test: in COLLECT, compare each raw sample with previous raw sample (both modes); run counter of identical samples reaching REPEAT_LIMIT -> ERROR next cycle.
REQ-022 Run counter resets to 1 on each change of value and on entry to COLLECT; first sample after entry starts a new run.
REQ-023 ERROR: trng_en=0, error=1, data_valid=0, busy=0; stays until enable=0, then -> IDLE.
REQ-024 enable=0 in WARMUP, COLLECT or VALID -> IDLE next cycle: trng_en=0, data_valid=0, partial word and counters discarded; error clears on enable=0.
REQ-025 enable=0 and data_ready handshake in same cycle: handshake completes, next state IDLE.
REQ-026 debias_en changes outside IDLE have no effect until next IDLE->WARMUP.
REQ-027 busy = (state==WARMUP)||(state==COLLECT); all outputs registered or decoded from state only.

Reset
REQ-028 reset=1 immediately forces state IDLE, trng_en=0, data=0, data_valid=0, busy=0, error=0, all counters and pair state 0.
REQ-029 After reset release, first possible trng_en=1 is the cycle after enable is sampled high.

Verification
REQ-030 WARMUP_CYCLES=4, raw, enable=1, trng_out alternating 1,0 from first COLLECT cycle -> trng_en high 1 cycle after enable, data_valid after 4+32 cycles plus transition, data=32'hAAAAAAAA.
REQ-031 Debias mode, pairs 10,01,00,11 repeated -> only bits 1,0 kept; after 16 repetitions (64 pairs) data=32'hAAAAAAAA.
REQ-032 REPEAT_LIMIT=8, raw, trng_out stuck 0 -> ERROR after 8th sample, trng_en=0, error=1; enable=0 -> IDLE, error=0.
REQ-033 data_ready held 0 for 10 cycles in VALID -> data and data_valid stable, trng_en=1; data_ready=1 -> next word collected, new data_valid after 32 further samples.
REQ-034 enable dropped mid-COLLECT after 17 bits, re-raised -> full WARMUP repeated, new word contains no stale bits.
REQ-035 reset asserted mid-COLLECT asynchronously (between clock edges) -> all outputs 0 before next edge; normal sequence after release.

Source files
------------

// File: rtl/trng_ctrl.sv
// trng_ctrl: controller for a ring-oscillator TRNG.
//   Runs a warm-up period, then gathers 32-bit words from the TRNG, either as
//   raw bits or through a von Neumann debiaser. Every raw sample also goes
//   through a repetition-count health test. Completed words are offered with a
//   valid/ready handshake.
// Ports:
//   clk        in   single clock; trng_out is sampled on the rising edge
//   reset      in   asynchronous, active-high reset
//   enable     in   level request to run; deasserting it aborts any activity
//   debias_en  in   1 = von Neumann debiasing, 0 = raw bits (latched in IDLE)
//   trng_en    out  enable to the ring-oscillator TRNG
//   trng_out   in   random bit from the TRNG, already in the clk domain
//   data       out  collected word, newest bit in bit 0
//   data_valid out  data holds a complete word
//   data_ready in   consumer accepts the word when data_valid && data_ready
//   busy       out  high while warming up or collecting
//   error      out  health-test failure; sticky until enable goes low
module trng_ctrl #(
  parameter int WARMUP_CYCLES = 64,
  parameter int REPEAT_LIMIT  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        debias_en,
  output logic        trng_en,
  input  logic        trng_out,
  output logic [31:0] data,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_COLLECT,
    S_VALID,
    S_ERROR
  } state_t;

  localparam logic [15:0] WARM_LAST = 16'(WARMUP_CYCLES - 1);
  localparam logic [8:0]  RUN_LIMIT = 9'(REPEAT_LIMIT);

  state_t      r_state;
  state_t      w_nstate;
  logic        r_mode;
  logic [15:0] r_wcnt;
  logic [5:0]  r_bcnt;
  logic [31:0] r_word;
  logic        r_pair_have;
  logic        r_pair_a;
  logic        r_prev;
  logic        r_prev_vld;
  logic [8:0]  r_run;
  logic        r_trng_en;
  logic        r_valid;
  logic        r_busy;
  logic        r_error;

  logic        w_same;
  logic [8:0]  w_run_nx;
  logic        w_trip;
  logic        w_emit;
  logic        w_bit;
  logic        w_done;
  logic        w_warm_done;

  always_comb begin
    // Health test: the first sample after entering COLLECT has no predecessor
    // and always starts a fresh run of length 1.
    w_same      = r_prev_vld && (trng_out == r_prev);
    w_run_nx    = w_same ? (r_run + 9'd1) : 9'd1;
    w_trip      = (w_run_nx >= RUN_LIMIT);
    // Debias mode only emits on the second sample of a pair, and only when the
    // two samples differ; the emitted bit is the first sample of the pair.
    w_emit      = r_mode ? (r_pair_have && (r_pair_a != trng_out)) : 1'b1;
    w_bit       = r_mode ? r_pair_a : trng_out;
    w_done      = w_emit && (r_bcnt == 6'd31);
    w_warm_done = (r_wcnt == WARM_LAST);

    w_nstate = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) w_nstate = S_WARMUP;
      end
      S_WARMUP: begin
        if (!enable)          w_nstate = S_IDLE;
        else if (w_warm_done) w_nstate = S_COLLECT;
      end
      S_COLLECT: begin
        // A health failure outranks a word completing on the same sample.
        if (!enable)     w_nstate = S_IDLE;
        else if (w_trip) w_nstate = S_ERROR;
        else if (w_done) w_nstate = S_VALID;
      end
      S_VALID: begin
        if (!enable)         w_nstate = S_IDLE;
        else if (data_ready) w_nstate = S_COLLECT;
      end
      S_ERROR: begin
        if (!enable) w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_wcnt      <= '0;
      r_bcnt      <= '0;
      r_word      <= '0;
      r_pair_have <= 1'b0;
      r_pair_a    <= 1'b0;
      r_prev      <= 1'b0;
      r_prev_vld  <= 1'b0;
      r_run       <= '0;
      r_trng_en   <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      // Outputs are registered from the next state so they line up with it.
      r_trng_en <= (w_nstate == S_WARMUP) || (w_nstate == S_COLLECT) ||
                   (w_nstate == S_VALID);
      r_busy    <= (w_nstate == S_WARMUP) || (w_nstate == S_COLLECT);
      r_valid   <= (w_nstate == S_VALID);
      r_error   <= (w_nstate == S_ERROR);

      if (r_state == S_IDLE) r_mode <= debias_en;

      r_wcnt <= (r_state == S_WARMUP) ? (r_wcnt + 16'd1) : '0;

      if (r_state == S_COLLECT) begin
        r_prev      <= trng_out;
        r_prev_vld  <= 1'b1;
        r_run       <= w_run_nx;
        r_pair_have <= r_mode ? ~r_pair_have : 1'b0;
        r_pair_a    <= trng_out;
        if (w_emit) begin
          r_word <= {r_word[30:0], w_bit};
          r_bcnt <= r_bcnt + 6'd1;
        end
      end else begin
        // Outside COLLECT nothing is sampled, so every (re)entry into COLLECT
        // starts with an empty bit count, pair state and run counter.
        r_bcnt      <= '0;
        r_pair_have <= 1'b0;
        r_pair_a    <= 1'b0;
        r_prev      <= 1'b0;
        r_prev_vld  <= 1'b0;
        r_run       <= '0;
      end
    end
  end

  assign trng_en    = r_trng_en;
  assign data       = r_word;
  assign data_valid = r_valid;
  assign busy       = r_busy;
  assign error      = r_error;

endmodule

// File: tb/tb_trng_ctrl.sv
// tb_trng_ctrl: self-checking bench for trng_ctrl with WARMUP_CYCLES=4 and
// REPEAT_LIMIT=8. A sample-sequence model predicts, from the list of bits seen
// in COLLECT, either the completed word and the sample that completes it, or
// the sample on which the repetition test fails.
module tb_trng_ctrl;

  localparam int W  = 4;
  localparam int RL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        debias_en;
  logic        trng_en;
  logic        trng_out;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        error;

  int errors = 0;
  int checks = 0;
  bit sq[$];

  always #5 clk = ~clk;

  trng_ctrl #(.WARMUP_CYCLES(W), .REPEAT_LIMIT(RL)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .debias_en  (debias_en),
    .trng_en    (trng_en),
    .trng_out   (trng_out),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .error      (error)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the sample list. Raw keeps every bit; debias looks at
  // pairs (0,1),(2,3),... and keeps the first bit when the two differ. The
  // health test counts identical consecutive samples from the first one.
  // kind: 0 = word done, 1 = health error, -1 = list too short.
  task automatic model(input bit mode, input bit seq[$], output int kind,
                       output int n, output logic [31:0] w);
    int run;
    int nbits;
    run = 0; nbits = 0; w = '0; kind = -1; n = 0;
    for (int k = 0; k < seq.size(); k++) begin
      if (k > 0 && seq[k] == seq[k-1]) run++;
      else run = 1;
      if (!mode) begin
        w = {w[30:0], seq[k]};
        nbits++;
      end else if (k % 2 == 1 && seq[k] != seq[k-1]) begin
        w = {w[30:0], seq[k-1]};
        nbits++;
      end
      if (run >= RL) begin kind = 1; n = k + 1; return; end
      if (nbits == 32) begin kind = 0; n = k + 1; return; end
    end
  endtask

  // Random bits; when limited, runs are capped below the health limit.
  task automatic gen(input int len, input bit limited);
    int run;
    bit b;
    sq.delete();
    run = 0;
    for (int k = 0; k < len; k++) begin
      b = 1'($urandom_range(0, 1));
      if (limited && k > 0 && b == sq[k-1] && run >= RL - 1) b = ~sq[k-1];
      if (k > 0 && b == sq[k-1]) run++;
      else run = 1;
      sq.push_back(b);
    end
  endtask

  // From IDLE: raise enable and run through the full warm-up. Returns with the
  // next rising edge being the first COLLECT sample.
  task automatic start(input bit mode);
    debias_en  = mode;
    data_ready = 1'b0;
    enable     = 1'b1;
    checks++;
    if (trng_en !== 1'b0 || busy !== 1'b0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_idle: trng_en=%b busy=%b valid=%b, want 0 0 0", trng_en, busy, data_valid);
    end
    tick();
    for (int i = 0; i < W; i++) begin
      checks++;
      if (trng_en !== 1'b1 || busy !== 1'b1 || data_valid !== 1'b0 || error !== 1'b0) begin
        errors++;
        $display("FAIL warmup[%0d]: trng_en=%b busy=%b valid=%b err=%b, want 1 1 0 0", i, trng_en, busy, data_valid, error);
      end
      trng_out = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic drive_and_check(input bit mode, input bit seq[$], input string tag,
                                 output int kind);
    int n;
    logic [31:0] w;
    model(mode, seq, kind, n, w);
    if (kind < 0) begin
      checks++; errors++;
      $display("FAIL %s: sample list exhausted before word or error", tag);
      return;
    end
    for (int k = 0; k < n; k++) begin
      trng_out = seq[k];
      tick();
      if (k < n - 1) begin
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b1 || error !== 1'b0 || trng_en !== 1'b1) begin
          errors++;
          $display("FAIL %s collect[%0d]: valid=%b busy=%b err=%b en=%b, want 0 1 0 1", tag, k, data_valid, busy, error, trng_en);
        end
      end
    end
    checks++;
    if (kind == 0) begin
      if (data_valid !== 1'b1 || data !== w || busy !== 1'b0 || trng_en !== 1'b1 || error !== 1'b0) begin
        errors++;
        $display("FAIL %s word: valid=%b data=%h busy=%b en=%b err=%b, want 1 %h 0 1 0", tag, data_valid, data, busy, trng_en, error, w);
      end
    end else begin
      if (error !== 1'b1 || trng_en !== 1'b0 || data_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s health: err=%b en=%b valid=%b busy=%b, want 1 0 0 0", tag, error, trng_en, data_valid, busy);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (trng_en !== 1'b0 || data_valid !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: en=%b valid=%b busy=%b err=%b, want 0 0 0 0", tag, trng_en, data_valid, busy, error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; debias_en = 1'b0; trng_out = 1'b0; data_ready = 1'b0;
    tick();
    checks++;
    if (trng_en !== 0 || data !== 32'h0 || data_valid !== 0 || busy !== 0 || error !== 0) begin
      errors++;
      $display("FAIL reset_state: en=%b data=%h valid=%b busy=%b err=%b, want all 0", trng_en, data, data_valid, busy, error);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (trng_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: trng_en=%b, want 0", trng_en);
    end
    enable = 1'b0;
    reset  = 1'b0;
    tick();
    check_idle("post_reset");
  endtask

  task automatic test_raw_alternating();
    int kind;
    sq.delete();
    for (int k = 0; k < 40; k++) sq.push_back(k % 2 == 0);
    start(1'b0);
    drive_and_check(1'b0, sq, "raw_alt", kind);
    checks++;
    if (data !== 32'hAAAAAAAA) begin
      errors++;
      $display("FAIL raw_alt_const: data=%h, want aaaaaaaa", data);
    end
  endtask

  task automatic test_backpressure();
    int kind;
    for (int i = 0; i < 10; i++) begin
      trng_out = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (data_valid !== 1'b1 || data !== 32'hAAAAAAAA || trng_en !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: valid=%b data=%h en=%b busy=%b, want 1 aaaaaaaa 1 0", i, data_valid, data, trng_en, busy);
      end
    end
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || busy !== 1'b1 || data !== 32'hAAAAAAAA) begin
      errors++;
      $display("FAIL handshake: valid=%b busy=%b data=%h, want 0 1 aaaaaaaa", data_valid, busy, data);
    end
    gen(40, 1'b1);
    drive_and_check(1'b0, sq, "next_word", kind);
    enable = 1'b0;
    tick();
    check_idle("after_next_word");
  endtask

  task automatic test_debias_pattern();
    int kind;
    sq.delete();
    for (int r = 0; r < 16; r++) begin
      sq.push_back(1); sq.push_back(0); sq.push_back(0); sq.push_back(1);
      sq.push_back(0); sq.push_back(0); sq.push_back(1); sq.push_back(1);
    end
    start(1'b1);
    drive_and_check(1'b1, sq, "debias_pat", kind);
    checks++;
    if (data !== 32'hAAAAAAAA) begin
      errors++;
      $display("FAIL debias_const: data=%h, want aaaaaaaa", data);
    end
    enable = 1'b0;
    tick();
    check_idle("after_debias");
  endtask

  task automatic test_health();
    int kind;
    sq.delete();
    for (int k = 0; k < 20; k++) sq.push_back(0);
    start(1'b0);
    drive_and_check(1'b0, sq, "stuck0", kind);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (error !== 1'b1 || trng_en !== 1'b0) begin
        errors++;
        $display("FAIL error_sticky[%0d]: err=%b en=%b, want 1 0", i, error, trng_en);
      end
    end
    enable = 1'b0;
    tick();
    check_idle("error_clear");
  endtask

  task automatic test_abort();
    int kind;
    start(1'b0);
    gen(17, 1'b1);
    for (int k = 0; k < 17; k++) begin
      trng_out = sq[k];
      tick();
      checks++;
      if (busy !== 1'b1 || data_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_collect[%0d]: busy=%b valid=%b, want 1 0", k, busy, data_valid);
      end
    end
    enable = 1'b0;
    tick();
    check_idle("abort");
    gen(40, 1'b1);
    start(1'b0);
    drive_and_check(1'b0, sq, "after_abort", kind);
    enable = 1'b0;
    tick();
    check_idle("after_abort_end");
  endtask

  task automatic test_random();
    int kind;
    bit mode;
    for (int it = 0; it < 8; it++) begin
      mode = 1'($urandom_range(0, 1));
      gen(600, it % 2 == 0);
      start(mode);
      debias_en = ~mode;
      drive_and_check(mode, sq, "random", kind);
      if (kind == 0) data_ready = 1'b1;
      enable = 1'b0;
      tick();
      data_ready = 1'b0;
      check_idle("random_end");
    end
  endtask

  task automatic test_async_reset();
    int kind;
    start(1'b0);
    gen(10, 1'b1);
    for (int k = 0; k < 10; k++) begin
      trng_out = sq[k];
      tick();
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (trng_en !== 0 || data !== 32'h0 || data_valid !== 0 || busy !== 0 || error !== 0) begin
      errors++;
      $display("FAIL async_reset: en=%b data=%h valid=%b busy=%b err=%b, want all 0", trng_en, data, data_valid, busy, error);
    end
    tick();
    reset = 1'b0;
    gen(40, 1'b1);
    start(1'b0);
    drive_and_check(1'b0, sq, "after_reset", kind);
    enable = 1'b0;
    tick();
    check_idle("after_reset_end");
  endtask

  initial begin
    test_reset();
    test_raw_alternating();
    test_backpressure();
    test_debias_pattern();
    test_health();
    test_abort();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
